// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: clock and active-high asynchronous reset bundle
interface fft_stage_sequencer_if;
  logic clk;
  logic rst;
  modport sink (input clk, rst);
endinterface

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: issues radix-2 DIT butterfly commands stage by stage with an outstanding cap and stage barrier
module fft_stage_sequencer #(
  parameter int N_LOG2 = 3,
  parameter int ADDR_W = N_LOG2,
  parameter int TW_W = N_LOG2 - 1,
  parameter int MAX_OUTSTANDING = 4
) (
  fft_stage_sequencer_if.sink clk_rstn_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(N_LOG2):0]  stage_o,
  output logic                     bf_valid_o,
  input  logic                     bf_ready_i,
  output logic [ADDR_W-1:0]        rd_addr0_o,
  output logic [ADDR_W-1:0]        rd_addr1_o,
  output logic [TW_W-1:0]          tw_addr_o,
  output logic                     bf_last_o,
  input  logic                     wb_valid_i
);
  localparam int SW = $clog2(N_LOG2) + 1;
  localparam int KW = N_LOG2 - 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [OW-1:0] outstanding, out_next;
  logic hs, spurious, can_issue;
  function automatic logic [2*ADDR_W+TW_W:0] cmd_f(input logic [SW-1:0] s, input logic [KW-1:0] kc);
    logic [ADDR_W-1:0] kk, half, pos, a0;
    kk = ADDR_W'(kc);
    half = ADDR_W'(1) << s;
    pos = kk & (half - 1'b1);
    a0 = ((kk >> s) << (s + 1'b1)) | pos;
    return {a0, a0 | half, TW_W'(pos << (SW'(KW) - s)), kc == K_LAST};
  endfunction
  always_comb begin
    hs = bf_valid_o & bf_ready_i;
    spurious = wb_valid_i & ~hs & (outstanding == '0);
    out_next = (hs & ~wb_valid_i) ? outstanding + 1'b1 :
               (~hs & wb_valid_i & (outstanding != '0)) ? outstanding - 1'b1 : outstanding;
    can_issue = out_next < OW'(MAX_OUTSTANDING);
  end
  always_ff @(posedge clk_rstn_i.clk or posedge clk_rstn_i.rst) begin
    if (clk_rstn_i.rst) begin
      state <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      stage_o <= '0;
      bf_valid_o <= 1'b0;
      {rd_addr0_o, rd_addr1_o, tw_addr_o, bf_last_o} <= '0;
      k <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      if (spurious) err_o <= 1'b1;
      case (state)
        IDLE: if (start_i) begin
          state <= ISSUE;
          busy_o <= 1'b1;
          err_o <= 1'b0;
          stage_o <= '0;
          k <= '0;
          bf_valid_o <= can_issue;
          {rd_addr0_o, rd_addr1_o, tw_addr_o, bf_last_o} <= cmd_f('0, '0);
        end
        ISSUE: if (hs && k == K_LAST) begin
          state <= DRAIN;
          k <= '0;
          bf_valid_o <= 1'b0;
        end else if (hs) begin
          k <= k + 1'b1;
          bf_valid_o <= can_issue;
          {rd_addr0_o, rd_addr1_o, tw_addr_o, bf_last_o} <= cmd_f(stage_o, k + 1'b1);
        end else if (!bf_valid_o) begin
          bf_valid_o <= can_issue;
        end
        // the stage barrier: next stage opens on the cycle the last writeback lands
        DRAIN: if (out_next == '0 && stage_o == S_LAST) begin
          state <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else if (out_next == '0) begin
          state <= ISSUE;
          stage_o <= stage_o + 1'b1;
          bf_valid_o <= 1'b1;
          {rd_addr0_o, rd_addr1_o, tw_addr_o, bf_last_o} <= cmd_f(stage_o + 1'b1, '0);
        end
        DONE: begin
          state <= IDLE;
          done_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: randomized bench against a butterfly-ordering and barrier model of an 8-point FFT run
module tb_fft_stage_sequencer;
  localparam int N_LOG2 = 3, N = 1 << N_LOG2, HALF = N / 2, TOTAL = N_LOG2 * HALF, MAXO = 4;
  fft_stage_sequencer_if cr();
  logic start_i = 0, bf_ready_i = 1, wb_valid_i = 0;
  logic busy_o, done_o, err_o, bf_valid_o, bf_last_o;
  logic [2:0] stage_o, rd_addr0_o, rd_addr1_o;
  logic [1:0] tw_addr_o;
  fft_stage_sequencer dut (.clk_rstn_i(cr), .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .stage_o(stage_o), .bf_valid_o(bf_valid_o), .bf_ready_i(bf_ready_i), .rd_addr0_o(rd_addr0_o),
    .rd_addr1_o(rd_addr1_o), .tw_addr_o(tw_addr_o), .bf_last_o(bf_last_o), .wb_valid_i(wb_valid_i));
  typedef struct {int a0; int a1; int tw;} cmd_t;
  cmd_t exp_cmd[TOTAL];
  int checks = 0, failures = 0;
  int log_a0[$], log_a1[$], log_tw[$], due_q[$];
  int m_out, m_idx, m_wbs, m_stage, cyc = 0, done_cnt = 0, stall_cnt = 0;
  bit m_run, m_held, m_err, m_done, run0, done0, hs, wbc, exp_v;
  int lat_min = 3, lat_max = 3, due, stall_idx = -1, stall_left = 0, credit = 0;
  bit rdy_rand = 0, wb_block = 0, force_wb = 0;
  int pa0[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int pa1[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int ptw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // textbook in-place DIT order: span-wide butterflies within each block of 2*span
  function automatic void build_table();
    int n = 0;
    for (int s = 0; s < N_LOG2; s++) begin
      int span = 1 << s;
      for (int base = 0; base < N; base += 2 * span)
        for (int j = 0; j < span; j++) begin
          exp_cmd[n] = '{base + j, base + j + span, j * (N / (2 * span))};
          n++;
        end
    end
  endfunction

  initial begin
    cr.clk = 0;
    forever #5 cr.clk = ~cr.clk;
  end

  always @(negedge cr.clk) begin
    if (cr.rst) begin
      m_out = 0; m_idx = 0; m_wbs = 0; m_stage = 0;
      m_run = 0; m_held = 0; m_err = 0; m_done = 0;
      due_q.delete();
    end else begin
      run0 = m_run;
      done0 = m_done;
      exp_v = m_held || (m_run && m_idx < TOTAL && m_wbs >= (m_idx / HALF) * HALF && m_out < MAXO);
      check("valid", bf_valid_o, exp_v);
      check("busy", busy_o, m_run);
      check("done", done_o, m_done);
      check("err", err_o, m_err);
      check("stage", stage_o, m_stage);
      if (bf_valid_o && m_idx < TOTAL) begin
        check("a0", rd_addr0_o, exp_cmd[m_idx].a0);
        check("a1", rd_addr1_o, exp_cmd[m_idx].a1);
        check("tw", tw_addr_o, exp_cmd[m_idx].tw);
        check("last", bf_last_o, m_idx % HALF == HALF - 1);
      end
      if (done_o) done_cnt++;
      if (bf_valid_o && !bf_ready_i) stall_cnt++;
      hs = bf_valid_o & bf_ready_i;
      if (hs) begin
        log_a0.push_back(rd_addr0_o);
        log_a1.push_back(rd_addr1_o);
        log_tw.push_back(tw_addr_o);
        m_idx++;
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due_q.size() > 0 && due < due_q[$]) due = due_q[$];
        due_q.push_back(due);
      end
      wbc = wb_valid_i && (m_out > 0 || hs);
      if (wb_valid_i && !wbc) m_err = 1;
      m_out = m_out + int'(hs) - int'(wbc);
      if (wbc) m_wbs++;
      m_held = bf_valid_o & !bf_ready_i;
      m_done = 0;
      if (wbc && m_wbs % HALF == 0) begin
        if (m_wbs == TOTAL) begin
          m_run = 0;
          m_done = 1;
        end else m_stage++;
      end
      if (start_i && !run0 && !done0) begin
        m_run = 1; m_idx = 0; m_wbs = 0; m_stage = 0; m_err = 0;
        log_a0.delete(); log_a1.delete(); log_tw.delete();
      end
    end
  end

  always @(posedge cr.clk) begin
    #1;
    cyc++;
    wb_valid_i = 0;
    if (force_wb) begin
      wb_valid_i = 1;
      force_wb = 0;
    end else if (due_q.size() > 0 && due_q[0] <= cyc && (!wb_block || credit > 0)) begin
      void'(due_q.pop_front());
      wb_valid_i = 1;
      if (wb_block) credit--;
    end
    if (stall_left > 0 && m_idx == stall_idx) begin
      bf_ready_i = 0;
      stall_left--;
    end else bf_ready_i = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge cr.clk);
      #2;
    end
  endtask

  task automatic do_start();
    start_i = 1;
    step();
    start_i = 0;
  endtask

  task automatic wait_done(input string nm);
    int d0 = done_cnt, t = 0;
    while (done_cnt == d0 && t < 3000) begin
      step();
      t++;
    end
    check({nm, "_completed"}, int'(done_cnt > d0), 1);
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_busy"}, busy_o, 0);
    check({nm, "_done"}, done_o, 0);
    check({nm, "_err"}, err_o, 0);
    check({nm, "_stage"}, stage_o, 0);
    check({nm, "_valid"}, bf_valid_o, 0);
    check({nm, "_last"}, bf_last_o, 0);
    check({nm, "_a0"}, rd_addr0_o, 0);
    check({nm, "_a1"}, rd_addr1_o, 0);
    check({nm, "_tw"}, tw_addr_o, 0);
  endtask

  initial begin
    int t, d0;
    build_table();
    cr.rst = 1;
    step(3);
    check_outputs_zero("reset");
    cr.rst = 0;
    step(2);
    // nominal run, fixed 3-cycle writeback latency, pinned to hand-derived order
    do_start();
    wait_done("nominal");
    check("nominal_count", log_a0.size(), TOTAL);
    for (int i = 0; i < 12 && i < log_a0.size(); i++) begin
      check($sformatf("plan_a0[%0d]", i), log_a0[i], pa0[i]);
      check($sformatf("plan_a1[%0d]", i), log_a1[i], pa1[i]);
      check($sformatf("plan_tw[%0d]", i), log_tw[i], ptw[i]);
    end
    check("nominal_err", err_o, 0);
    check("nominal_done_cnt", done_cnt, 1);
    step(3);
    // backpressure on s1 k1, plus start pulses during ISSUE and DONE
    stall_cnt = 0; stall_idx = 5; stall_left = 5;
    d0 = done_cnt;
    do_start();
    t = 0;
    while (m_idx < 2 && t < 200) begin step(); t++; end
    do_start();
    t = 0;
    while (!done_o && t < 500) begin step(); t++; end
    check("bp_done_seen", done_o, 1);
    do_start();
    step(6);
    check("bp_one_done", done_cnt - d0, 1);
    check("bp_idle_busy", busy_o, 0);
    check("bp_count", log_a0.size(), TOTAL);
    check("bp_stalls", stall_cnt, 5);
    if (log_a0.size() > 5) begin
      check("bp_a0", log_a0[5], 1);
      check("bp_a1", log_a1[5], 3);
      check("bp_tw", log_tw[5], 2);
    end
    stall_idx = -1;
    // outstanding cap and stage barrier with writebacks withheld
    wb_block = 1; credit = 0;
    do_start();
    step(12);
    check("cap_issued", m_idx, 4);
    check("cap_valid", bf_valid_o, 0);
    check("cap_stage", stage_o, 0);
    credit = 1;
    step(8);
    check("barrier_issued", m_idx, 4);
    check("barrier_stage", stage_o, 0);
    credit = 2;
    step(8);
    check("barrier_stage3", stage_o, 0);
    credit = 1;
    step(8);
    check("barrier_stage4", stage_o, 1);
    check("barrier_s1_issued", m_idx, 8);
    check("barrier_s1_valid", bf_valid_o, 0);
    wb_block = 0;
    wait_done("cap");
    // asynchronous reset mid-s1, spurious writeback, restart
    do_start();
    t = 0;
    while (m_idx < 6 && t < 300) begin step(); t++; end
    check("rst_reached_s1", stage_o, 1);
    @(posedge cr.clk);
    #3 cr.rst = 1;
    #1 check_outputs_zero("async_rst");
    step(2);
    cr.rst = 0;
    step(2);
    force_wb = 1;
    step(3);
    check("spurious_err", err_o, 1);
    do_start();
    check("restart_err_clr", err_o, 0);
    check("restart_stage", stage_o, 0);
    wait_done("restart");
    if (log_a0.size() > 0) begin
      check("restart_a0", log_a0[0], 0);
      check("restart_a1", log_a1[0], 1);
      check("restart_tw", log_tw[0], 0);
    end
    check("restart_count", log_a0.size(), TOTAL);
    // randomized ready and writeback latency
    rdy_rand = 1;
    for (int r = 0; r < 6; r++) begin
      lat_min = 1;
      lat_max = 1 + $urandom_range(5);
      do_start();
      wait_done($sformatf("rand%0d", r));
      check($sformatf("rand%0d_count", r), log_a0.size(), TOTAL);
      step($urandom_range(3));
    end
    check("total_done", done_cnt, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
